// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : IF/ID pipeline register, instruction decode, 32x32 register file
//            with write-through bypass, and early branch resolution.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTRF,
    input  logic [31:0] PCPLUS4F,
    input  logic        STALLD,
    input  logic        FLUSHD,
    input  logic        WE3W,
    input  logic [4:0]  WA3W,
    input  logic [31:0] WD3W,
    input  logic        FWDAD,
    input  logic        FWDBD,
    input  logic [31:0] ALUOUTM,
    output logic        WRITEREGD,
    output logic        MEMTOREGD,
    output logic        MEMWRITED,
    output logic        ALUSRCD,
    output logic        REGDSTD,
    output logic [1:0]  ALUCONTROLD,
    output logic [31:0] rd1D,
    output logic [31:0] rd2D,
    output logic [4:0]  rsD,
    output logic [4:0]  rtD,
    output logic [4:0]  rdD,
    output logic [31:0] SIGNIMMD,
    output logic        PCSRCD,
    output logic [31:0] PCBRANCHD
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;

    logic [31:0] r_instr_d;
    logic [31:0] r_pcplus4_d;
    logic [31:0] r_regs [32];

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [15:0] w_imm;
    logic [31:0] w_signimm;
    logic        w_wr_en;
    logic        w_byp_en;
    logic        w_branch;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [31:0] w_cmp_a;
    logic [31:0] w_cmp_b;

    // IF/ID register: stall outranks flush
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_instr_d   <= '0;
            r_pcplus4_d <= '0;
        end else if (!STALLD) begin
            if (FLUSHD) begin
                r_instr_d   <= '0;
                r_pcplus4_d <= '0;
            end else begin
                r_instr_d   <= INSTRF;
                r_pcplus4_d <= PCPLUS4F;
            end
        end
    end

    assign w_op      = r_instr_d[31:26];
    assign w_rs      = r_instr_d[25:21];
    assign w_rt      = r_instr_d[20:16];
    assign w_funct   = r_instr_d[5:0];
    assign w_imm     = r_instr_d[15:0];
    assign w_signimm = {{16{w_imm[15]}}, w_imm};

    assign w_wr_en  = WE3W && (WA3W != 5'd0);
    // Bypass is masked by RST so a writeback bus left active during reset cannot leak out
    assign w_byp_en = w_wr_en && RST;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < 32; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[WA3W] <= WD3W;
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_rs != 5'd0) begin
            w_rd1 = (w_byp_en && (WA3W == w_rs)) ? WD3W : r_regs[w_rs];
        end
        if (w_rt != 5'd0) begin
            w_rd2 = (w_byp_en && (WA3W == w_rt)) ? WD3W : r_regs[w_rt];
        end
    end

    always_comb begin
        WRITEREGD   = 1'b0;
        MEMTOREGD   = 1'b0;
        MEMWRITED   = 1'b0;
        ALUSRCD     = 1'b0;
        REGDSTD     = 1'b0;
        w_branch    = 1'b0;
        ALUCONTROLD = 2'b00;
        case (w_op)
            c_OP_RTYPE: begin
                case (w_funct)
                    c_FN_ADD: begin WRITEREGD = 1'b1; REGDSTD = 1'b1; ALUCONTROLD = 2'b00; end
                    c_FN_SUB: begin WRITEREGD = 1'b1; REGDSTD = 1'b1; ALUCONTROLD = 2'b01; end
                    c_FN_AND: begin WRITEREGD = 1'b1; REGDSTD = 1'b1; ALUCONTROLD = 2'b10; end
                    c_FN_OR:  begin WRITEREGD = 1'b1; REGDSTD = 1'b1; ALUCONTROLD = 2'b11; end
                    default: ;
                endcase
            end
            c_OP_LW: begin
                WRITEREGD = 1'b1;
                MEMTOREGD = 1'b1;
                ALUSRCD   = 1'b1;
            end
            c_OP_SW: begin
                MEMWRITED = 1'b1;
                ALUSRCD   = 1'b1;
            end
            c_OP_ADDI: begin
                WRITEREGD = 1'b1;
                ALUSRCD   = 1'b1;
            end
            c_OP_BEQ: begin
                w_branch    = 1'b1;
                ALUCONTROLD = 2'b01;
            end
            default: ;
        endcase
    end

    assign w_cmp_a = FWDAD ? ALUOUTM : w_rd1;
    assign w_cmp_b = FWDBD ? ALUOUTM : w_rd2;

    assign rd1D      = w_rd1;
    assign rd2D      = w_rd2;
    assign rsD       = w_rs;
    assign rtD       = w_rt;
    assign rdD       = r_instr_d[15:11];
    assign SIGNIMMD  = w_signimm;
    assign PCSRCD    = w_branch && (w_cmp_a == w_cmp_b);
    assign PCBRANCHD = r_pcplus4_d + {w_signimm[29:0], 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Directed and randomized checks of decode_stage against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INSTRF, PCPLUS4F, WD3W, ALUOUTM;
    logic        STALLD, FLUSHD, WE3W, FWDAD, FWDBD;
    logic [4:0]  WA3W;
    logic        WRITEREGD, MEMTOREGD, MEMWRITED, ALUSRCD, REGDSTD, PCSRCD;
    logic [1:0]  ALUCONTROLD;
    logic [31:0] rd1D, rd2D, SIGNIMMD, PCBRANCHD;
    logic [4:0]  rsD, rtD, rdD;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_instr;
    logic [31:0] m_pc;

    always #5 CLK = ~CLK;

    decode_stage dut (
        .CLK(CLK), .RST(RST), .INSTRF(INSTRF), .PCPLUS4F(PCPLUS4F),
        .STALLD(STALLD), .FLUSHD(FLUSHD), .WE3W(WE3W), .WA3W(WA3W), .WD3W(WD3W),
        .FWDAD(FWDAD), .FWDBD(FWDBD), .ALUOUTM(ALUOUTM),
        .WRITEREGD(WRITEREGD), .MEMTOREGD(MEMTOREGD), .MEMWRITED(MEMWRITED),
        .ALUSRCD(ALUSRCD), .REGDSTD(REGDSTD), .ALUCONTROLD(ALUCONTROLD),
        .rd1D(rd1D), .rd2D(rd2D), .rsD(rsD), .rtD(rtD), .rdD(rdD),
        .SIGNIMMD(SIGNIMMD), .PCSRCD(PCSRCD), .PCBRANCHD(PCBRANCHD)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // {writereg, memtoreg, memwrite, alusrc, regdst, branch, aluctl[1:0]}
    function automatic logic [7:0] m_decode(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'd0 && fn == 6'h20) return 8'b1000_1000;
        if (op == 6'd0 && fn == 6'h22) return 8'b1000_1001;
        if (op == 6'd0 && fn == 6'h24) return 8'b1000_1010;
        if (op == 6'd0 && fn == 6'h25) return 8'b1000_1011;
        if (op == 6'h23) return 8'b1101_0000;
        if (op == 6'h2B) return 8'b0011_0000;
        if (op == 6'h08) return 8'b1001_0000;
        if (op == 6'h04) return 8'b0000_0101;
        return 8'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0 || !RST) return 32'd0;
        if (WE3W && WA3W == a) return WD3W;
        return m_regs[a];
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
        m_instr = 32'd0;
        m_pc    = 32'd0;
    endtask

    task automatic check_all();
        logic [7:0]  ctl;
        logic [31:0] simm, r1, r2, a, b;
        ctl  = m_decode(m_instr);
        simm = 32'($signed(m_instr[15:0]));
        r1   = m_read(m_instr[25:21]);
        r2   = m_read(m_instr[20:16]);
        a    = FWDAD ? ALUOUTM : r1;
        b    = FWDBD ? ALUOUTM : r2;
        check("WRITEREGD", 32'(WRITEREGD), 32'(ctl[7]));
        check("MEMTOREGD", 32'(MEMTOREGD), 32'(ctl[6]));
        check("MEMWRITED", 32'(MEMWRITED), 32'(ctl[5]));
        check("ALUSRCD", 32'(ALUSRCD), 32'(ctl[4]));
        check("REGDSTD", 32'(REGDSTD), 32'(ctl[3]));
        check("ALUCONTROLD", 32'(ALUCONTROLD), 32'(ctl[1:0]));
        check("rd1D", rd1D, r1);
        check("rd2D", rd2D, r2);
        check("rsD", 32'(rsD), 32'(m_instr[25:21]));
        check("rtD", 32'(rtD), 32'(m_instr[20:16]));
        check("rdD", 32'(rdD), 32'(m_instr[15:11]));
        check("SIGNIMMD", SIGNIMMD, simm);
        check("PCSRCD", 32'(PCSRCD), 32'(ctl[2] && (a == b)));
        check("PCBRANCHD", PCBRANCHD, m_pc + simm * 4);
    endtask

    // Check current outputs, clock once, advance the model, return just after the falling edge
    task automatic cycle();
        #1;
        check_all();
        @(posedge CLK);
        if (!RST) begin
            m_clear();
        end else begin
            if (WE3W && WA3W != 5'd0) m_regs[WA3W] = WD3W;
            if (!STALLD) begin
                m_instr = FLUSHD ? 32'd0 : INSTRF;
                m_pc    = FLUSHD ? 32'd0 : PCPLUS4F;
            end
        end
        @(negedge CLK);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        WE3W = 1'b1;
        WA3W = a;
        WD3W = d;
        cycle();
        WE3W = 1'b0;
    endtask

    initial begin
        RST = 1'b0; INSTRF = 32'd0; PCPLUS4F = 32'd0; STALLD = 1'b0; FLUSHD = 1'b0;
        WE3W = 1'b0; WA3W = 5'd0; WD3W = 32'd0; FWDAD = 1'b0; FWDBD = 1'b0; ALUOUTM = 32'd0;
        m_clear();
        cycle();
        check("reset_rd1D", rd1D, 32'd0);
        check("reset_PCBRANCHD", PCBRANCHD, 32'd0);
        RST = 1'b1;

        // Asynchronous reset between edges while add $3,$5,$6 is decoded
        WE3W = 1'b1; WA3W = 5'd5; WD3W = 32'h55; INSTRF = 32'h00A61820; PCPLUS4F = 32'h40;
        cycle();
        WE3W = 1'b0;
        #1;
        check("pre_reset_rd1D", rd1D, 32'h55);
        RST = 1'b0;
        m_clear();
        #1;
        check("async_WRITEREGD", 32'(WRITEREGD), 32'd0);
        check("async_rd1D", rd1D, 32'd0);
        check("async_rdD", 32'(rdD), 32'd0);
        cycle();
        RST = 1'b1;
        cycle();
        check("post_reset_reg5", rd1D, 32'd0);

        // add with written operands
        wb(5'd5, 32'h00001234);
        wb(6'd6, 32'h00000010);
        INSTRF = 32'h00A61820;
        cycle();
        #1;
        check("add_rd1D", rd1D, 32'h00001234);
        check("add_rd2D", rd2D, 32'h00000010);
        check("add_rdD", 32'(rdD), 32'd3);
        check("add_WRITEREGD", 32'(WRITEREGD), 32'd1);
        check("add_REGDSTD", 32'(REGDSTD), 32'd1);
        check("add_ALUCONTROLD", 32'(ALUCONTROLD), 32'd0);

        // Write-through bypass, then writes to r0 are dropped
        WE3W = 1'b1; WA3W = 5'd5; WD3W = 32'hDEADBEEF;
        #1;
        check("bypass_rd1D", rd1D, 32'hDEADBEEF);
        cycle();
        WA3W = 5'd0; WD3W = 32'hFFFFFFFF; INSTRF = 32'h00001820;
        cycle();
        #1;
        check("zero_rd1D", rd1D, 32'd0);
        WE3W = 1'b0;

        // beq $4,$2,-1 resolved with forwarded operand B
        wb(5'd4, 32'd7);
        INSTRF = 32'h1082FFFF; PCPLUS4F = 32'h100;
        cycle();
        FWDBD = 1'b1; ALUOUTM = 32'd7;
        #1;
        check("beq_PCSRCD_taken", 32'(PCSRCD), 32'd1);
        check("beq_PCBRANCHD", PCBRANCHD, 32'h000000FC);
        ALUOUTM = 32'd8;
        #1;
        check("beq_PCSRCD_not", 32'(PCSRCD), 32'd0);
        cycle();
        FWDBD = 1'b0;

        // Stall holds lw, flush clears, stall beats flush
        INSTRF = 32'h8C220004;
        cycle();
        STALLD = 1'b1; INSTRF = 32'h00A61820;
        cycle();
        cycle();
        check("stall_MEMTOREGD", 32'(MEMTOREGD), 32'd1);
        check("stall_ALUSRCD", 32'(ALUSRCD), 32'd1);
        STALLD = 1'b0; FLUSHD = 1'b1;
        cycle();
        check("flush_WRITEREGD", 32'(WRITEREGD), 32'd0);
        check("flush_MEMTOREGD", 32'(MEMTOREGD), 32'd0);
        FLUSHD = 1'b0; INSTRF = 32'h8C220004;
        cycle();
        STALLD = 1'b1; FLUSHD = 1'b1;
        cycle();
        check("stallflush_MEMTOREGD", 32'(MEMTOREGD), 32'd1);
        STALLD = 1'b0; FLUSHD = 1'b0;

        // Illegal opcode and unsupported funct
        INSTRF = 32'hFC000000;
        cycle();
        check("illegal_op_WRITEREGD", 32'(WRITEREGD), 32'd0);
        check("illegal_op_SIGNIMMD", SIGNIMMD, 32'd0);
        INSTRF = 32'h00A6182A;
        cycle();
        check("illegal_fn_REGDSTD", 32'(REGDSTD), 32'd0);
        check("illegal_fn_SIGNIMMD", SIGNIMMD, 32'h0000182A);
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [5:0] ops [8];
            logic [5:0] fns [6];
            ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h04, 6'h3F};
            fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
            INSTRF   = $urandom;
            INSTRF[31:26] = ops[$urandom_range(0, 7)];
            if (INSTRF[31:26] == 6'h00) INSTRF[5:0] = fns[$urandom_range(0, 5)];
            INSTRF[25:21] = 5'($urandom_range(0, 7));
            INSTRF[20:16] = 5'($urandom_range(0, 7));
            PCPLUS4F = $urandom;
            STALLD   = ($urandom_range(0, 5) == 0);
            FLUSHD   = ($urandom_range(0, 5) == 0);
            WE3W     = $urandom_range(0, 1) == 1;
            WA3W     = 5'($urandom_range(0, 7));
            WD3W     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            FWDAD    = $urandom_range(0, 1) == 1;
            FWDBD    = $urandom_range(0, 1) == 1;
            ALUOUTM  = ($urandom_range(0, 1) == 1) ? m_read(m_instr[25:21]) : m_read(m_instr[20:16]);
            if ($urandom_range(0, 3) == 0) ALUOUTM = $urandom;
            cycle();
        end

        // Reset asserted with a pending load and write on the bus
        INSTRF = 32'h00A61820; WE3W = 1'b1; WA3W = 5'd5; WD3W = 32'h77;
        RST = 1'b0;
        m_clear();
        cycle();
        check("reset_bypass_rd1D", rd1D, 32'd0);
        RST = 1'b1; WE3W = 1'b0;
        cycle();
        check("reset_discard_reg5", rd1D, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports: CLK  in  1  clock, all state updates on rising edge; RST  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: INSTRF  in  32  fetched instruction; PCPLUS4F  in  32  PC+4 of fetched instruction.
REQ-003 SHALL have ports: STALLD  in  1  hold IF/ID register; FLUSHD  in  1  clear IF/ID register.
REQ-004 SHALL have ports: WE3W  in  1  writeback enable; WA3W  in  5  writeback register; WD3W  in  32  writeback data.
REQ-005 SHALL have ports: FWDAD, FWDBD  in  1 each  select ALUOUTM for branch compare operand A/B; ALUOUTM  in  32  memory-stage ALU result.
REQ-006 SHALL have ports: WRITEREGD, MEMTOREGD, MEMWRITED, ALUSRCD, REGDSTD  out  1 each  control to ID/EX; ALUCONTROLD  out  2  ALU op.
REQ-007 SHALL have ports: rd1D, rd2D  out  32  register operands; rsD, rtD, rdD  out  5  register fields; SIGNIMMD  out  32  sign-extended immediate.
REQ-008 SHALL have ports: PCSRCD  out  1  branch taken; PCBRANCHD  out  32  branch target.

Function
REQ-009 SHALL hold an IF/ID register (INSTRD, PCPLUS4D, 64 bits): on CLK rise, STALLD=1 holds; else FLUSHD=1 loads zero; else loads INSTRF/PCPLUS4F.
REQ-010 STALLD SHALL take priority over FLUSHD when both are 1.
REQ-011 Fields from INSTRD: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0]; rsD/rtD/rdD SHALL equal those fields combinationally.
REQ-012 SIGNIMMD SHALL be {16{imm[15]}, imm}.
REQ-013 Decode SHALL be combinational from INSTRD, giving {WRITEREGD, MEMTOREGD, MEMWRITED, ALUSRCD, REGDSTD, BRANCH, ALUCONTROLD}:
  - op 000000 funct 100000 add: 1,0,0,0,1,0,00
  - op 000000 funct 100010 sub: 1,0,0,0,1,0,01
  - op 000000 funct 100100 and: 1,0,0,0,1,0,10
  - op 000000 funct 100101 or: 1,0,0,0,1,0,11
  - op 100011 lw: 1,1,0,1,0,0,00
  - op 101011 sw: 0,0,1,1,0,0,00
  - op 001000 addi: 1,0,0,1,0,0,00
  - op 000100 beq: 0,0,0,0,0,1,01
  - any other op/funct: all zero (NOP).
REQ-014 SHALL contain a 32x32-bit register file; on CLK rise with WE3W=1 and WA3W!=0, reg[WA3W] <= WD3W.
REQ-015 Writes to register 0 SHALL be ignored; reads of register 0 SHALL return 0.
REQ-016 rd1D/rd2D SHALL read reg[rs]/reg[rt] combinationally with write-through bypass: if WE3W=1, WA3W!=0 and WA3W equals the read address, output WD3W.
REQ-017 Branch compare: A = FWDAD ? ALUOUTM : rd1D; B = FWDBD ? ALUOUTM : rd2D; PCSRCD = BRANCH & (A==B).
REQ-018 PCBRANCHD SHALL be PCPLUS4D + (SIGNIMMD << 2), modulo 2^32 (wrap, no overflow flag).
REQ-019 All outputs SHALL be combinational from INSTRD, PCPLUS4D, register file and same-cycle inputs; decode latency is one cycle after INSTRF is sampled.

Reset
REQ-020 RST=0 SHALL immediately, independent of CLK, clear INSTRD, PCPLUS4D and all 32 registers to 0.
REQ-021 While RST=0, outputs SHALL be: all control 0, ALUCONTROLD=00, rd1D=rd2D=0, rsD=rtD=rdD=0, SIGNIMMD=0, PCSRCD=0, PCBRANCHD=0 (WD3W bypass suppressed during reset).
REQ-022 RST assertion mid-operation SHALL discard any pending IF/ID contents and register writes in that cycle; first load occurs on the first CLK rise after RST=1.

Verification
REQ-023 Reset: load add $3,$5,$6, assert RST=0 between edges -> all outputs 0 immediately; after release, reg5 reads 0.
REQ-024 Write reg5=0x00001234, reg6=0x10 via WB, then INSTRF=0x00A61820 (add $3,$5,$6) -> next cycle rd1D=0x00001234, rd2D=0x10, rdD=3, WRITEREGD=1, REGDSTD=1, ALUCONTROLD=00.
REQ-025 Bypass/zero: WE3W=1, WA3W=5, WD3W=0xDEADBEEF same cycle as decoding rs=5 -> rd1D=0xDEADBEEF; WA3W=0, WD3W=0xFFFFFFFF -> reg0 still reads 0.
REQ-026 Branch: reg4=7, beq $4,$2,-1 (0x1082FFFF), PCPLUS4F=0x100, FWDBD=1, ALUOUTM=7 -> PCSRCD=1, PCBRANCHD=0x000000FC; ALUOUTM=8 -> PCSRCD=0.
REQ-027 Stall/flush: lw loaded, STALLD=1 for 2 cycles with new INSTRF -> lw outputs held (MEMTOREGD=1, ALUSRCD=1); STALLD=0, FLUSHD=1 -> next cycle all control 0; STALLD=1, FLUSHD=1 -> held.
REQ-028 Illegal: INSTRF=0xFC000000 and R-type funct 101010 -> all control outputs 0, SIGNIMMD per immediate.
